gpr_write_arbiter: RTL and testbench

Shares the single write port of the 32×32 general-purpose register file between two writeback requesters: A, the ALU/immediate path, and B, the load/multi-cycle unit. Each requester has a one-entry holding buffer behind a valid/ready handshake. A round-robin arbiter drains the buffers at one write per cycle onto registered `regwrite`/`m1out`/`m2out` outputs, which drive the register file directly. Writes to `$0` are accepted and discarded here, so `$0` never reaches the register file's write port.

---
 rtl/gpr_write_arbiter_if.sv | 30 +++
 rtl/gpr_write_arbiter.sv | 117 +++++++++++
 tb/tb_gpr_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_write_arbiter_if.sv
// Write-request and register-file-port bundle for gpr_write_arbiter.
// master: the requester/observer side; slave: the arbiter itself.
interface gpr_write_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          regwrite;
  logic [AW-1:0] m1out;
  logic [DW-1:0] m2out;
  logic [7:0]    zero_drops;
  logic          idle;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, regwrite, m1out, m2out, zero_drops, idle
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, regwrite, m1out, m2out, zero_drops, idle
  );
endinterface

// File: rtl/gpr_write_arbiter.sv
// Two-requester round-robin arbiter for the single register-file write port.
// Each requester has a one-entry holding buffer; writes to $0 are swallowed
// here and counted instead of being sent to the register file.
module gpr_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic              clk,
  input logic              reset,
  gpr_write_arbiter_if.slave bus
);
  logic          hold_a_v;
  logic [AW-1:0] hold_a_addr;
  logic [DW-1:0] hold_a_data;
  logic          hold_b_v;
  logic [AW-1:0] hold_b_addr;
  logic [DW-1:0] hold_b_data;
  logic          last_b;
  logic          grant_a;
  logic          grant_b;
  logic          a_ready;
  logic          b_ready;
  logic          take_a;
  logic          take_b;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          regwrite_q;
  logic [AW-1:0] m1out_q;
  logic [DW-1:0] m2out_q;
  logic [7:0]    zero_drops_q;

  // Round-robin grant over buffer valids; ready passes the grant through so a
  // granted full buffer can refill on the same edge.
  always_comb begin
    grant_a  = hold_a_v && (!hold_b_v || last_b);
    grant_b  = hold_b_v && !grant_a;
    a_ready  = !hold_a_v || grant_a;
    b_ready  = !hold_b_v || grant_b;
    take_a   = bus.a_valid && a_ready;
    take_b   = bus.b_valid && b_ready;
    sel_addr = grant_a ? hold_a_addr : hold_b_addr;
    sel_data = grant_a ? hold_a_data : hold_b_data;
  end

  // Holding buffer A: load on transfer, otherwise clear once granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_a_v    <= 1'b0;
      hold_a_addr <= '0;
      hold_a_data <= '0;
    end else if (take_a) begin
      hold_a_v    <= 1'b1;
      hold_a_addr <= bus.a_addr;
      hold_a_data <= bus.a_data;
    end else if (grant_a) begin
      hold_a_v    <= 1'b0;
    end
  end

  // Holding buffer B: same behaviour as A.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_b_v    <= 1'b0;
      hold_b_addr <= '0;
      hold_b_data <= '0;
    end else if (take_b) begin
      hold_b_v    <= 1'b1;
      hold_b_addr <= bus.b_addr;
      hold_b_data <= bus.b_data;
    end else if (grant_b) begin
      hold_b_v    <= 1'b0;
    end
  end

  // Round-robin pointer; reset to 1 so A wins the first contest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_b <= 1'b1;
    end else if (grant_a) begin
      last_b <= 1'b0;
    end else if (grant_b) begin
      last_b <= 1'b1;
    end
  end

  // Registered write port; $0 grants become a drop count instead of a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q   <= 1'b0;
      m1out_q      <= '0;
      m2out_q      <= '0;
      zero_drops_q <= '0;
    end else if (grant_a || grant_b) begin
      if (sel_addr != '0) begin
        regwrite_q <= 1'b1;
        m1out_q    <= sel_addr;
        m2out_q    <= sel_data;
      end else begin
        regwrite_q <= 1'b0;
        if (zero_drops_q != 8'hFF) zero_drops_q <= zero_drops_q + 8'd1;
      end
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  // Output drive.
  always_comb begin
    bus.a_ready    = a_ready;
    bus.b_ready    = b_ready;
    bus.regwrite   = regwrite_q;
    bus.m1out      = m1out_q;
    bus.m2out      = m2out_q;
    bus.zero_drops = zero_drops_q;
    bus.idle       = !hold_a_v && !hold_b_v && !regwrite_q;
  end
endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Self-checking bench for gpr_write_arbiter: directed scenarios followed by
// compliant random traffic, all compared cycle by cycle against a queue model.
module tb_gpr_write_arbiter;
  logic clk;
  logic reset;
  gpr_write_arbiter_if #(.DW(32), .AW(5)) bus ();

  gpr_write_arbiter #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  int n_checks = 0;
  int n_errors = 0;

  // model: per-requester pending entries (at most one each) and the port
  wr_t         qa[$];
  wr_t         qb[$];
  bit          m_lastb;
  bit          m_rw;
  logic [4:0]  m_m1;
  logic [31:0] m_m2;
  int          m_drops;
  int          win;
  bit          stall_a;
  bit          stall_b;
  int          n_acc_nz;
  int          n_written;
  logic [31:0] rf [32];

  // protocol monitor for B: addr/data must not move while stalled
  int          b_viol = 0;
  bit          prev_b_stall = 1'b0;
  logic [4:0]  prev_b_addr;
  logic [31:0] prev_b_data;
  always @(posedge clk) begin
    if (reset && prev_b_stall && bus.b_valid &&
        (bus.b_addr !== prev_b_addr || bus.b_data !== prev_b_data))
      b_viol++;
    prev_b_stall = reset && bus.b_valid && !bus.b_ready;
    prev_b_addr  = bus.b_addr;
    prev_b_data  = bus.b_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    qa.delete();
    qb.delete();
    m_lastb = 1'b1;
    m_rw    = 1'b0;
    m_m1    = '0;
    m_m2    = '0;
    m_drops = 0;
    stall_a = 1'b0;
    stall_b = 1'b0;
  endfunction

  function automatic void pick();
    if (qa.size() != 0 && qb.size() != 0) win = m_lastb ? 1 : 2;
    else if (qa.size() != 0)              win = 1;
    else if (qb.size() != 0)              win = 2;
    else                                  win = 0;
  endfunction

  function automatic void retire(input wr_t w);
    if (w.addr != 0) begin
      m_rw = 1'b1;
      m_m1 = w.addr;
      m_m2 = w.data;
    end else begin
      m_rw = 1'b0;
      if (m_drops < 255) m_drops++;
    end
  endfunction

  // One clock: inputs already driven; check readies, take the edge, check port.
  task automatic step();
    bit  exp_ar, exp_br, acc_a, acc_b;
    wr_t in_a, in_b, w;
    #1;
    pick();
    exp_ar = (qa.size() == 0) || (win == 1);
    exp_br = (qb.size() == 0) || (win == 2);
    check("a_ready", 32'(bus.a_ready), 32'(exp_ar));
    check("b_ready", 32'(bus.b_ready), 32'(exp_br));
    acc_a   = bus.a_valid && exp_ar;
    acc_b   = bus.b_valid && exp_br;
    stall_a = bus.a_valid && !exp_ar;
    stall_b = bus.b_valid && !exp_br;
    in_a    = {bus.a_addr, bus.a_data};
    in_b    = {bus.b_addr, bus.b_data};
    @(posedge clk);
    #1;
    if (win == 1) begin
      w = qa.pop_front();
      m_lastb = 1'b0;
      retire(w);
    end else if (win == 2) begin
      w = qb.pop_front();
      m_lastb = 1'b1;
      retire(w);
    end else begin
      m_rw = 1'b0;
    end
    if (acc_a) begin
      qa.push_back(in_a);
      if (in_a.addr != 0) n_acc_nz++;
    end
    if (acc_b) begin
      qb.push_back(in_b);
      if (in_b.addr != 0) n_acc_nz++;
    end
    check("regwrite", 32'(bus.regwrite), 32'(m_rw));
    check("m1out", 32'(bus.m1out), 32'(m_m1));
    check("m2out", bus.m2out, m_m2);
    check("zero_drops", 32'(bus.zero_drops), 32'(m_drops));
    check("idle", 32'(bus.idle), 32'(qa.size() == 0 && qb.size() == 0 && !m_rw));
    if (bus.regwrite) begin
      rf[bus.m1out] = bus.m2out;
      n_written++;
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
  endtask

  task automatic idle_steps(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset mid-cycle, immediate checks, release at the negedge.
  task automatic reset_pulse();
    drive(0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_regwrite", 32'(bus.regwrite), 32'd0);
    check("rst_m1out", 32'(bus.m1out), 32'd0);
    check("rst_m2out", bus.m2out, 32'd0);
    check("rst_zero_drops", 32'(bus.zero_drops), 32'd0);
    check("rst_a_ready", 32'(bus.a_ready), 32'd1);
    check("rst_b_ready", 32'(bus.b_ready), 32'd1);
    check("rst_idle", 32'(bus.idle), 32'd1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int base;

  initial begin
    n_acc_nz  = 0;
    n_written = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    #3;
    check("por_regwrite", 32'(bus.regwrite), 32'd0);
    check("por_idle", 32'(bus.idle), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // reset with both buffers full and a write on the port
    drive(1, 5'd1, 32'h100, 1, 5'd2, 32'h200);
    step();
    drive(1, 5'd4, 32'h400, 1, 5'd2, 32'h200);
    step();
    check("pre_rst_regwrite", 32'(bus.regwrite), 32'd1);
    reset_pulse();
    drive(1, 5'd3, 32'h33, 0, 0, 0);
    step();
    idle_steps(1);
    check("first_after_rst_addr", 32'(bus.m1out), 32'd3);
    idle_steps(2);

    // single requester streaming
    drive(1, 5'd1, 32'h11, 0, 0, 0); step();
    drive(1, 5'd2, 32'h22, 0, 0, 0); step();
    drive(1, 5'd3, 32'h33, 0, 0, 0); step();
    idle_steps(3);

    // contention fairness from reset
    reset_pulse();
    base = n_written;
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'(4 + i), 32'hA0 + 32'(i), 1, 5'(10 + i), 32'hB0 + 32'(i));
      step();
      while (stall_a || stall_b) begin
        if (!stall_a) bus.a_valid = 1'b0;
        if (!stall_b) bus.b_valid = 1'b0;
        step();
      end
    end
    idle_steps(4);
    check("contention_writes", 32'(n_written - base), 32'd12);

    // $0 suppression and saturation
    drive(1, 5'd0, 32'hDEAD, 0, 0, 0); step();
    drive(1, 5'd5, 32'h55, 0, 0, 0);   step();
    idle_steps(3);
    check("zero_drops_one", 32'(bus.zero_drops), 32'd1);
    for (int i = 0; i < 300; i++) begin
      drive(1, 5'd0, 32'(i), 0, 0, 0);
      step();
    end
    idle_steps(3);
    check("zero_drops_sat", 32'(bus.zero_drops), 32'd255);
    reset_pulse();

    // same-address collision, pointer favouring A
    rf[7] = '0;
    drive(1, 5'd7, 32'hA, 1, 5'd7, 32'hB); step();
    idle_steps(4);
    check("collision_r7", rf[7], 32'hB);

    // deliberate B stability violation seen by the monitor
    reset_pulse();
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'hD1); step();
    drive(1, 5'd3, 32'h3, 1, 5'd4, 32'hD2); step();
    drive(0, 0, 0, 1, 5'd4, 32'hD3);        step();
    idle_steps(4);
    check("b_violation_seen", 32'(b_viol), 32'd1);

    // compliant random traffic
    reset_pulse();
    base = n_written;
    n_acc_nz = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!stall_a) begin
        bus.a_valid = ($urandom_range(0, 3) != 0);
        bus.a_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.a_data  = $urandom;
      end
      if (!stall_b) begin
        bus.b_valid = ($urandom_range(0, 3) != 0);
        bus.b_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.b_data  = $urandom;
      end
      step();
    end
    idle_steps(4);
    check("random_no_loss_dup", 32'(n_written - base), 32'(n_acc_nz));
    check("random_compliant", 32'(b_viol), 32'd1);
    check("random_drained_idle", 32'(bus.idle), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
